// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the sequential chunked adder.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SLICE = 8;

    function automatic int calc_nchunk(input int width, input int slice);
        return width / slice;
    endfunction

    // A single chunk still needs a one-bit index so the counter never has zero width.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder shared by the sequencer across all chunks.
module adder_slice #(
    parameter int SLICE = 8
) (
    output logic             co,
    output logic [SLICE-1:0] sum,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};

endmodule

// File: rtl/add_seq_ctrl.sv
// Time-shares one adder_slice over a WIDTH-bit add, LSB chunk first, one chunk per cycle.
// Optional subtract support is enabled by defining ADD_SEQ_SUB_EN.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    localparam int NCHUNK = calc_nchunk(WIDTH, SLICE);
    localparam int IDX_W  = calc_idx_w(NCHUNK);

    if ((WIDTH % SLICE) != 0) begin : g_bad_width
        $error("add_seq_ctrl: WIDTH must be a multiple of SLICE");
    end

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   b_eff;
    logic               carry;
    logic               carry_init;
    logic [IDX_W-1:0]   idx;
    logic               last_chunk;
    logic               accept;
    logic [SLICE-1:0]   slice_a;
    logic [SLICE-1:0]   slice_b;
    logic [SLICE-1:0]   slice_sum;
    logic               slice_co;

`ifdef ADD_SEQ_SUB_EN
    logic               sub_reg;

    // Subtraction is a + ~b + 1: invert B per chunk and seed the carry with 1.
    assign b_eff      = sub_reg ? ~b_reg : b_reg;
    assign carry_init = sub ? 1'b1 : ci;
`else
    assign b_eff      = b_reg;
    assign carry_init = ci;
`endif

    assign accept     = (state == IDLE) && in_valid;
    assign last_chunk = (idx == IDX_W'(NCHUNK - 1));

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDX_W'(k)) begin
                slice_a = a_reg[k*SLICE +: SLICE];
                slice_b = b_eff[k*SLICE +: SLICE];
            end
        end
    end

    adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .co  (slice_co),
        .sum (slice_sum),
        .a   (slice_a),
        .b   (slice_b),
        .ci  (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            co    <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_reg <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_reg <= a;
                b_reg <= b;
                carry <= carry_init;
                idx   <= '0;
`ifdef ADD_SEQ_SUB_EN
                sub_reg <= sub;
`endif
            end else if (state == RUN) begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx == IDX_W'(k)) begin
                        sum[k*SLICE +: SLICE] <= slice_sum;
                    end
                end
                carry <= slice_co;
                if (last_chunk) begin
                    co  <= slice_co;
                    idx <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (WIDTH=32, SLICE=8); subtract cases need ADD_SEQ_SUB_EN.
module tb_add_seq_ctrl;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_co;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
`ifdef ADD_SEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             busy;

    int errors = 0;
    int checks = 0;

    add_seq_ctrl #(
        .WIDTH (WIDTH),
        .SLICE (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word arithmetic, carry-out is bit WIDTH of the wide result.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                             input logic mci, input logic msub);
        if (msub)
            return {1'b0, ma} + {1'b0, ~mb} + (WIDTH+1)'(1);
        return {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mci};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Issue one op, measure latency, optionally stall in DONE for hold cycles, then retire it.
    task automatic applyStimulus(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vci, input logic vsub, input logic [WIDTH-1:0] exp_sum,
                                 input logic exp_co, input int hold);
        int lat;
        int wait_cyc;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        checkOutput({name, " in_ready"}, 64'(in_ready), 64'd1);
        a        = va;
        b        = vb;
        ci       = vci;
`ifdef ADD_SEQ_SUB_EN
        sub      = vsub;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        ci       = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, " latency"}, 64'(lat), 64'd4);
        checkOutput({name, " sum"}, 64'(sum), 64'(exp_sum));
        checkOutput({name, " co"}, 64'(co), 64'(exp_co));
        for (int h = 0; h < hold; h++) begin
            checkOutput({name, " hold out_valid"}, 64'(out_valid), 64'd1);
            checkOutput({name, " hold sum"}, 64'(sum), 64'(exp_sum));
            checkOutput({name, " hold co"}, 64'(co), 64'(exp_co));
            checkOutput({name, " hold in_ready"}, 64'(in_ready), 64'd0);
            in_valid = (h == 1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({name, " idle after retire"}, 64'(busy), 64'd0);
        if (vsub == 1'b1 && vci == 1'b1) ;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        logic [WIDTH:0]   exp_q[$];
        logic [WIDTH:0]   ref_val;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rci;
        int               acc_cyc[3];
        int               acc;
        int               seen;
        int               cyc;
        logic             acc_now;

        vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0});
        vecs.push_back('{32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1});
`ifdef ADD_SEQ_SUB_EN
        vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1});
        sub = 1'b0;
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        #1;
        checkOutput("reset in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset sum", 64'(sum), 64'd0);
        checkOutput("reset co", 64'(co), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("release in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub,
                          vecs[i].exp_sum, vecs[i].exp_co, 0);
        end

        $display("[TB] DONE stall with ignored in_valid");
        applyStimulus("stall", 32'h0000ABCD, 32'h00001111, 1'b1, 1'b0, 32'h0000BCDF, 1'b0, 5);

        $display("[TB] reset mid-run");
        a        = 32'h11111111;
        b        = 32'h22222222;
        ci       = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst sum", 64'(sum), 64'd0);
        checkOutput("midrst busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checkOutput("post-rst no out_valid", 64'(out_valid), 64'd0);
        end
        applyStimulus("post-rst 3+4", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 0);

        $display("[TB] random ops against model");
        for (int k = 0; k < 8; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            rci = 1'($urandom_range(0, 1));
            ref_val = model(ra, rb, rci, 1'b0);
            applyStimulus("rand", ra, rb, rci, 1'b0, ref_val[WIDTH-1:0], ref_val[WIDTH], 0);
        end
`ifdef ADD_SEQ_SUB_EN
        for (int k = 0; k < 6; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            rci = 1'($urandom_range(0, 1));
            ref_val = model(ra, rb, rci, 1'b1);
            applyStimulus("rand sub", ra, rb, rci, 1'b1, ref_val[WIDTH-1:0], ref_val[WIDTH], 0);
        end
        sub = 1'b0;
`endif

        $display("[TB] back-to-back streaming");
        a         = $urandom;
        b         = $urandom;
        ci        = 1'($urandom_range(0, 1));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc  = 0;
        seen = 0;
        cyc  = 0;
        while (seen < 3 && cyc < 60) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("stream unexpected result", 64'd1, 64'd0);
                end else begin
                    ref_val = exp_q.pop_front();
                    checkOutput("stream sum", 64'(sum), 64'(ref_val[WIDTH-1:0]));
                    checkOutput("stream co", 64'(co), 64'(ref_val[WIDTH]));
                end
                seen++;
            end
            acc_now = 1'b0;
            if (in_ready && acc < 3) begin
                exp_q.push_back(model(a, b, ci, 1'b0));
                acc_cyc[acc] = cyc;
                acc++;
                acc_now = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                if (acc < 3) begin
                    a  = $urandom;
                    b  = $urandom;
                    ci = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("stream results seen", 64'(seen), 64'd3);
        if (acc == 3) begin
            checkOutput("stream spacing 0-1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
            checkOutput("stream spacing 1-2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd6);
        end else begin
            checkOutput("stream accepts", 64'(acc), 64'd3);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
